neuron_scheduler: RTL
=====================

# neuron_scheduler

Time-multiplexed controller that shares one membrane-update datapath across `N_NEURONS` virtual neurons. It holds per-neuron membrane state, stimulus and refractory counters in registers. On each `tick` it sweeps all neurons in index order through a fetch/compute/write sequence and reports spikes as indexed events plus a per-neuron vector. It sits between the stimulus/config source and the spike consumer, replacing one update datapath per neuron.

## Interface
Parameters:
- `N_NEURONS`, 4: number of virtual neurons; power of two, 2–16.
- `IDX_W`, `$clog2(N_NEURONS)`: neuron index width.
- `LEAK_SHIFT`, 2: leak term is `v >> LEAK_SHIFT`.
- `THRESH_INIT`, 32: reset value of the threshold register.
- `REFRACT`, 2: number of ticks a neuron is held after it spikes; 0–15.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `tick` in 1: single-cycle request to run one update sweep.
- `stim_we` in 1: write `stim_data` to `stim[stim_idx]`.
- `stim_idx` in `IDX_W`: stimulus write index.
- `stim_data` in 8: unsigned stimulus current.
- `thr_we` in 1: write threshold.
- `thr_data` in 8: new threshold.
- `busy` out 1: sweep in progress.
- `spike_valid` out 1: single-cycle spike event.
- `spike_idx` out `IDX_W`: index of the spiking neuron; valid when `spike_valid` is 1.
- `spike_vec` out `N_NEURONS`: per-neuron spike result of that neuron's latest update.
- `overrun` out 1: sticky flag, set when a tick is dropped.

## Operation
- FSM states: `IDLE`, `FETCH`, `COMPUTE`, `WRITE`.
  - `IDLE` goes to `FETCH` with `idx=0` on `tick` or `pending`.
  - `FETCH` registers `v[idx]`, `stim[idx]` and `refr[idx]`, then goes to `COMPUTE`.
  - `COMPUTE` registers the datapath result, then goes to `WRITE`.
  - `WRITE` commits the result. If `idx==N_NEURONS-1`, go to `IDLE`; otherwise go to `FETCH` with `idx+1`.
- Update arithmetic, computed 10-bit unsigned: `sum = v + stim - (v >> LEAK_SHIFT)`. Subtraction cannot underflow. `v' = (sum > 255) ? 255 : sum`.
- Not refractory (`refr==0`): if `v' >= threshold`, the neuron spikes. On a spike: write `v=0`, load `refr=REFRACT`, set `spike_vec[idx]=1`, pulse `spike_valid` with `spike_idx=idx`. Without a spike: write `v=v'` and set `spike_vec[idx]=0`.
- Refractory (`refr>0`): write `v=0`, decrement `refr`, set `spike_vec[idx]=0`. Stimulus is ignored.
- Stimulus and threshold writes are accepted in any state and are persistent; `stim` is not cleared after use.
  - A same-cycle write and `FETCH` of the same index gives `FETCH` the old value.
  - The threshold is sampled in `COMPUTE`.
- Tick handling:
  - A tick in `IDLE` starts a sweep.
  - A tick while busy sets `pending`.
  - A tick while `pending` is already set sets `overrun`; that tick is lost.
  - `pending` is consumed by `IDLE`, so sweeps run back-to-back.
  - A tick arriving in the final `WRITE` cycle counts as busy and sets `pending`.

## Timing
- Reset values: all `v`, `stim` and `refr` = 0; `threshold=THRESH_INIT`; FSM in `IDLE`; `idx`, `pending`, `busy`, `spike_valid`, `spike_idx`, `spike_vec` and `overrun` all 0.
- Reset is effective immediately on assertion, including mid-sweep. The interrupted sweep is not resumed.
- `tick` sampled at edge T puts the FSM in `FETCH` (neuron 0) after T. `busy` is 1 from T+1 through the last `WRITE` cycle.
- Each neuron takes 3 cycles and a sweep takes `3*N_NEURONS` cycles (12 at default). The next sweep can start no earlier than 1 `IDLE` cycle later.
- For neuron k, `spike_valid` is high during cycle T+3k+3, counted from the first `FETCH` at T+1. `spike_vec` and `v` update at the end of that cycle.

## Structure
- Package `neuron_pkg` holds:
  - the FSM state enum;
  - the 8-bit membrane/stimulus width constant;
  - default `THRESH_INIT`, `LEAK_SHIFT` and `REFRACT`.
- Sub-module `neuron_update` is a combinational function `(v, stim, refr, threshold)` → `(v_next, refr_next, spike)`, registered by the scheduler in `COMPUTE`.

## Test plan
All scenarios use default parameters.
- Reset: all outputs are 0; threshold reads back as 32 via a spike test; `busy=0`.
- Integration: `stim[0]=10`, other stims 0, repeated ticks.
  - `v0` sequence: 10, 18, 24, 28, 31.
  - On the 6th tick, `sum=34` gives `spike_valid` with `spike_idx=0` at cycle T+3, and `v0=0`.
- Refractory: continue the integration scenario. Ticks 7–8 leave `v0=0` with no spike; tick 9 gives `v0=10`.
- Saturation: `thr=255`, `stim[1]=200`. Tick 1 gives `v1=200` with no spike; tick 2 gives `sum=350` saturated to 255, so neuron 1 spikes at cycle T+6.
- Tick overrun:
  - A tick at cycle 5 of a sweep sets `pending`, and a second sweep follows after 1 `IDLE` cycle.
  - Two ticks during one sweep set `overrun=1`, which stays 1 until reset.
- Async reset mid-sweep: drop `rst_n` during `COMPUTE` of neuron 2. `busy`, `v` and `spike_vec` clear without waiting for a clock edge; after release, `IDLE` waits for `tick`.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and defaults for the time-multiplexed neuron scheduler.
// Membrane/stimulus width, refractory counter width, FSM states.
package neuron_pkg;

  localparam int DW            = 8;
  localparam int RW            = 4;
  localparam int THRESH_INIT_D = 32;
  localparam int LEAK_SHIFT_D  = 2;
  localparam int REFRACT_D     = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_COMPUTE,
    S_WRITE
  } state_t;

endpackage

// File: rtl/neuron_scheduler_if.sv
// Control, stimulus/threshold write and spike report bundle.
// master drives requests and writes; slave is the scheduler.
interface neuron_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int IDX_W     = $clog2(N_NEURONS)
);

  logic                 tick;
  logic                 stim_we;
  logic [IDX_W-1:0]     stim_idx;
  logic [7:0]           stim_data;
  logic                 thr_we;
  logic [7:0]           thr_data;
  logic                 busy;
  logic                 spike_valid;
  logic [IDX_W-1:0]     spike_idx;
  logic [N_NEURONS-1:0] spike_vec;
  logic                 overrun;

  modport master (
    output tick,
    output stim_we,
    output stim_idx,
    output stim_data,
    output thr_we,
    output thr_data,
    input  busy,
    input  spike_valid,
    input  spike_idx,
    input  spike_vec,
    input  overrun
  );

  modport slave (
    input  tick,
    input  stim_we,
    input  stim_idx,
    input  stim_data,
    input  thr_we,
    input  thr_data,
    output busy,
    output spike_valid,
    output spike_idx,
    output spike_vec,
    output overrun
  );

endinterface

// File: rtl/neuron_update.sv
// Combinational leaky integrate-and-fire step for one neuron.
// Saturates at 255; refractory neurons are clamped to zero.
module neuron_update
  import neuron_pkg::*;
#(
  parameter int LEAK_SHIFT = LEAK_SHIFT_D,
  parameter int REFRACT    = REFRACT_D
) (
  input  logic [DW-1:0] i_v,
  input  logic [DW-1:0] i_stim,
  input  logic [RW-1:0] i_refr,
  input  logic [DW-1:0] i_thr,
  output logic [DW-1:0] o_v_next,
  output logic [RW-1:0] o_refr_next,
  output logic          o_spike
);

  logic [9:0]    w_sum;
  logic [DW-1:0] w_leak;
  logic [DW-1:0] w_vsat;

  assign w_leak = i_v >> LEAK_SHIFT;
  assign w_sum  = {2'b00, i_v} + {2'b00, i_stim}
                - {2'b00, w_leak};
  assign w_vsat = (w_sum > 10'd255) ? 8'hFF : w_sum[7:0];

  always_comb begin
    o_v_next    = '0;
    o_refr_next = '0;
    o_spike     = 1'b0;
    unique case (1'b1)
      (i_refr != '0): begin
        o_refr_next = i_refr - RW'(1);
      end
      (i_refr == '0): begin
        if (w_vsat >= i_thr) begin
          o_spike     = 1'b1;
          o_refr_next = RW'(REFRACT);
        end else begin
          o_v_next = w_vsat;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/neuron_scheduler.sv
// Sweeps N virtual neurons through one shared update datapath.
// Each neuron: FETCH, COMPUTE, WRITE; ticks queue once, then overrun.
module neuron_scheduler
  import neuron_pkg::*;
#(
  parameter int N_NEURONS   = 4,
  parameter int IDX_W       = $clog2(N_NEURONS),
  parameter int LEAK_SHIFT  = LEAK_SHIFT_D,
  parameter int THRESH_INIT = THRESH_INIT_D,
  parameter int REFRACT     = REFRACT_D
) (
  input logic                clk,
  input logic                rst_n,
  neuron_scheduler_if.slave  bus
);

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [DW-1:0]        r_v    [N_NEURONS];
  logic [DW-1:0]        r_stim [N_NEURONS];
  logic [RW-1:0]        r_refr [N_NEURONS];
  logic [DW-1:0]        r_thr;
  logic [DW-1:0]        r_fv;
  logic [DW-1:0]        r_fs;
  logic [RW-1:0]        r_fr;
  logic [DW-1:0]        r_cv;
  logic [RW-1:0]        r_cr;
  logic                 r_pending;
  logic                 r_busy;
  logic                 r_spike_valid;
  logic [IDX_W-1:0]     r_spike_idx;
  logic [N_NEURONS-1:0] r_spike_vec;
  logic                 r_overrun;

  logic [DW-1:0] w_v_next;
  logic [RW-1:0] w_refr_next;
  logic          w_spike;
  logic          w_last;

  neuron_update #(
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACT    (REFRACT)
  ) u_update (
    .i_v         (r_fv),
    .i_stim      (r_fs),
    .i_refr      (r_fr),
    .i_thr       (r_thr),
    .o_v_next    (w_v_next),
    .o_refr_next (w_refr_next),
    .o_spike     (w_spike)
  );

  assign w_last = (r_idx == IDX_W'(N_NEURONS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_thr         <= DW'(THRESH_INIT);
      r_fv          <= '0;
      r_fs          <= '0;
      r_fr          <= '0;
      r_cv          <= '0;
      r_cr          <= '0;
      r_pending     <= 1'b0;
      r_busy        <= 1'b0;
      r_spike_valid <= 1'b0;
      r_spike_idx   <= '0;
      r_spike_vec   <= '0;
      r_overrun     <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        r_v[i]    <= '0;
        r_stim[i] <= '0;
        r_refr[i] <= '0;
      end
    end else begin
      if (bus.stim_we) r_stim[bus.stim_idx] <= bus.stim_data;
      if (bus.thr_we)  r_thr <= bus.thr_data;

      // A tick landing while a sweep is queued is dropped
      if (r_state == S_IDLE) begin
        r_pending <= r_pending & bus.tick;
      end else if (bus.tick) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (bus.tick || r_pending) begin
            r_state <= S_FETCH;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_fv    <= r_v[r_idx];
          r_fs    <= r_stim[r_idx];
          r_fr    <= r_refr[r_idx];
          r_state <= S_COMPUTE;
        end
        S_COMPUTE: begin
          r_cv          <= w_v_next;
          r_cr          <= w_refr_next;
          r_spike_valid <= w_spike;
          if (w_spike) r_spike_idx <= r_idx;
          r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_spike_valid      <= 1'b0;
          r_v[r_idx]         <= r_cv;
          r_refr[r_idx]      <= r_cr;
          r_spike_vec[r_idx] <= r_spike_valid;
          if (w_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_state <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.spike_valid = r_spike_valid;
  assign bus.spike_idx   = r_spike_idx;
  assign bus.spike_vec   = r_spike_vec;
  assign bus.overrun     = r_overrun;

endmodule
